// File: rtl/spi_resp_pkg.sv
// rtl/spi_resp_pkg.sv - shared state encoding and default parameters for the SPI responder
package spi_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int         DEF_DATA_W      = 8;
  localparam int         DEF_SYNC_STAGES = 2;
  localparam logic [7:0] DEF_IDLE_FILL   = 8'hFF;

endpackage

// File: rtl/spi_resp_sync_edge.sv
// rtl/spi_resp_sync_edge.sv - multi-flop pin synchronizer with registered rise/fall strobes
module spi_sync_edge #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to the idle pin level so releasing reset never fakes an edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q <= {STAGES{RESET_LEVEL}};
      prev_q <= RESET_LEVEL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 responder with oversampled pins, 1-entry tx buffer and rx strobe
module spi_responder
  import spi_resp_pkg::*;
#(
  parameter int                 DATA_W      = DEF_DATA_W,
  parameter int                 SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [DATA_W-1:0]  IDLE_FILL   = DATA_W'(DEF_IDLE_FILL)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic ss_level_unused, ss_rise, ss_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_sclk (
    .Clk(Clk), .Reset(Reset), .pin(spi_sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_ss (
    .Clk(Clk), .Reset(Reset), .pin(spi_ss_n),
    .level(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_mosi (
    .Clk(Clk), .Reset(Reset), .pin(spi_mosi),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] buf_data;
  logic              word_done;
  logic              do_load;
  logic [DATA_W-1:0] load_word;

  // A load happens once at frame start and again at every word boundary falling edge.
  assign do_load   = !ss_rise &&
                     ((state == LOAD) ||
                      (state == SHIFT && sclk_fall && bit_cnt == '0));
  assign load_word = tx_ready ? IDLE_FILL : buf_data;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      buf_data    <= '0;
      word_done   <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      tx_ready    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      word_done   <= 1'b0;

      if (word_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end

      if (tx_valid && tx_ready) begin
        buf_data <= tx_data;
        tx_ready <= 1'b0;
      end

      if (ss_rise) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        rx_shift    <= '0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall) state <= LOAD;
          end
          LOAD: begin
            busy        <= 1'b1;
            spi_miso_oe <= 1'b1;
            state       <= SHIFT;
          end
          SHIFT: begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[DATA_W-2:0], mosi_level};
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                bit_cnt   <= '0;
                word_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (sclk_fall && bit_cnt != '0) begin
              tx_shift <= tx_shift << 1;
              spi_miso <= tx_shift[DATA_W-2];
            end
          end
          default: state <= IDLE;
        endcase
      end

      // A write landing on the same edge as an empty-buffer load is kept for the next word.
      if (do_load) begin
        tx_shift <= load_word;
        spi_miso <= load_word[DATA_W-1];
        if (tx_ready) tx_underrun <= 1'b1;
        else          tx_ready    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - directed self-checking bench for spi_responder
module tb_spi_responder;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       spi_sclk, spi_ss_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_underrun = 0;
  logic [7:0] rx_q[$];

  spi_responder dut (
    .Clk(Clk), .Reset(Reset),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  always #10 Clk = ~Clk;

  always @(negedge Clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_underrun) n_underrun++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fab_write(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge Clk);
    tx_valid = 1'b0;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    if (spi_sclk) spi_sclk = 1'b0;
    spi_mosi = b;
    repeat (5) @(negedge Clk);
    m = spi_miso;
    spi_sclk = 1'b1;
    repeat (5) @(negedge Clk);
  endtask

  task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(mo[i], m);
      mi[i] = m;
    end
  endtask

  task automatic frame_start();
    spi_ss_n = 1'b0;
    repeat (10) @(negedge Clk);
  endtask

  // SCLK stays high after the last bit until select has gone away.
  task automatic frame_end();
    spi_ss_n = 1'b1;
    repeat (6) @(negedge Clk);
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    repeat (10) @(negedge Clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] mi, mi2;
    logic       m;
    int         r0, u0;

    Reset = 1'b1; spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    repeat (5) @(negedge Clk);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_oe", 32'(spi_miso_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);

    // Plain byte, nothing buffered
    r0 = rx_q.size(); u0 = n_underrun;
    frame_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_oe", 32'(spi_miso_oe), 32'd1);
    spi_byte(8'hA5, mi);
    frame_end();
    check("t1_miso", 32'(mi), 32'hFF);
    check("t1_rx_cnt", 32'(rx_q.size() - r0), 32'd1);
    check("t1_rx_data", 32'(rx_q[$]), 32'hA5);
    check("t1_underrun", 32'(n_underrun - u0), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Buffered word before select
    u0 = n_underrun;
    fab_write(8'h3C);
    check("t2_ready_low", 32'(tx_ready), 32'd0);
    frame_start();
    check("t2_ready_load", 32'(tx_ready), 32'd1);
    spi_byte(8'h00, mi);
    frame_end();
    check("t2_miso", 32'(mi), 32'h3C);
    check("t2_underrun", 32'(n_underrun - u0), 32'd0);
    check("t2_rx_data", 32'(rx_q[$]), 32'h00);

    // Two-byte frame, second word written mid-frame
    r0 = rx_q.size(); u0 = n_underrun;
    fab_write(8'h12);
    frame_start();
    check("t3_ready", 32'(tx_ready), 32'd1);
    fab_write(8'h34);
    spi_byte(8'h81, mi);
    spi_byte(8'h7E, mi2);
    frame_end();
    check("t3_miso0", 32'(mi), 32'h12);
    check("t3_miso1", 32'(mi2), 32'h34);
    check("t3_rx_cnt", 32'(rx_q.size() - r0), 32'd2);
    check("t3_rx0", 32'(rx_q[rx_q.size()-2]), 32'h81);
    check("t3_rx1", 32'(rx_q[$]), 32'h7E);
    check("t3_underrun", 32'(n_underrun - u0), 32'd0);

    // Aborted byte after five SCLK edges
    r0 = rx_q.size();
    frame_start();
    spi_bit(1'b1, m);
    spi_bit(1'b0, m);
    spi_bit(1'b1, m);
    spi_ss_n = 1'b1;
    repeat (4) @(negedge Clk);
    check("t4_oe", 32'(spi_miso_oe), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    spi_sclk = 1'b0;
    repeat (10) @(negedge Clk);
    check("t4_no_rx", 32'(rx_q.size() - r0), 32'd0);
    frame_start();
    spi_byte(8'hC3, mi);
    frame_end();
    check("t4_rx_cnt", 32'(rx_q.size() - r0), 32'd1);
    check("t4_rx_data", 32'(rx_q[$]), 32'hC3);

    // Write on the same edge as the frame-start load
    r0 = rx_q.size(); u0 = n_underrun;
    spi_ss_n = 1'b0;
    repeat (3) @(negedge Clk);
    fab_write(8'h96);
    check("t5_ready_low", 32'(tx_ready), 32'd0);
    repeat (8) @(negedge Clk);
    spi_byte(8'hAA, mi);
    spi_byte(8'h55, mi2);
    frame_end();
    check("t5_miso0", 32'(mi), 32'hFF);
    check("t5_miso1", 32'(mi2), 32'h96);
    check("t5_underrun", 32'(n_underrun - u0), 32'd1);
    check("t5_rx0", 32'(rx_q[rx_q.size()-2]), 32'hAA);
    check("t5_rx1", 32'(rx_q[$]), 32'h55);
    check("t5_ready_end", 32'(tx_ready), 32'd1);

    // Asynchronous reset mid-byte
    frame_start();
    fab_write(8'h77);
    check("t6_ready_low", 32'(tx_ready), 32'd0);
    for (int i = 0; i < 4; i++) spi_bit(i[0], m);
    @(negedge Clk);
    #3 Reset = 1'b1;
    #1;
    check("t6_oe", 32'(spi_miso_oe), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_miso", 32'(spi_miso), 32'd0);
    check("t6_ready", 32'(tx_ready), 32'd1);
    check("t6_rx_data", 32'(rx_data), 32'd0);
    spi_ss_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    repeat (5) @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    r0 = rx_q.size(); u0 = n_underrun;
    frame_start();
    spi_byte(8'h5A, mi);
    frame_end();
    check("t6_miso_after", 32'(mi), 32'hFF);
    check("t6_rx_cnt", 32'(rx_q.size() - r0), 32'd1);
    check("t6_rx_data_after", 32'(rx_q[$]), 32'h5A);
    check("t6_underrun", 32'(n_underrun - u0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
